// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-port, byte-addressed Y86-64 memory between instruction
// fetch and the data (Memory stage) port. Accesses are serialised through an
// IDLE -> ISSUE -> RESP FSM. Data has priority because it belongs to the older
// instruction; a starvation counter forces a fetch grant after STARVE_MAX
// consecutive data grants taken while fetch was waiting.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_gnt)
//   if_gnt, if_rvalid              grant pulse, response pulse
//   if_rdata, if_err               fetched 8 bytes (little-endian), range error
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_gnt)
//   dm_gnt, dm_rvalid              grant pulse, response/write-ack pulse
//   dm_rdata, dm_err               read data (0 on write or error), range error
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe, write enable, address, data
//   mem_rdata                      memory read data, valid on the edge after mem_en
module dmem_port_arbiter #(
   parameter int MEM_BYTES  = 1024,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [63:0] if_rdata,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [63:0] dm_addr,
   input  logic [63:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [63:0] dm_rdata,
   output logic        dm_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   localparam int          SC_W       = $clog2(STARVE_MAX) + 1;
   localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - 8);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t          state;
   logic [SC_W-1:0] sc;
   logic            win_if_p0;
   logic            we_p0;
   logic            err_p0;

   // Comparing against MEM_BYTES-8 (rather than computing addr+8) cannot wrap
   // for addresses close to 2^64.
   function automatic logic addr_bad(input logic [63:0] a);
      return a > ADDR_LIMIT;
   endfunction

   function automatic logic [63:0] resp_data(input logic [63:0] rd,
                                             input logic        we,
                                             input logic        err);
      return (we || err) ? 64'd0 : rd;
   endfunction

   // Arbitration decode; only consumed at an arbitration edge, never drives an
   // output combinationally.
   logic        arb_go;
   logic        pick_if;
   logic [63:0] sel_addr;
   logic        sel_we;
   logic        sel_bad;

   always_comb begin
      arb_go   = ((state == IDLE) || (state == RESP)) && (if_req || dm_req);
      pick_if  = if_req && (!dm_req || (sc == SC_W'(STARVE_MAX)));
      sel_addr = pick_if ? if_addr : dm_addr;
      sel_we   = !pick_if && dm_we;
      sel_bad  = addr_bad(sel_addr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sc        <= '0;
         win_if_p0 <= 1'b0;
         we_p0     <= 1'b0;
         err_p0    <= 1'b0;
         if_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         if_err    <= 1'b0;
         dm_gnt    <= 1'b0;
         dm_rvalid <= 1'b0;
         dm_rdata  <= '0;
         dm_err    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         case (state)
            IDLE, RESP: begin
               // Arbitration -> ISSUE
               if (arb_go) begin
                  state     <= ISSUE;
                  win_if_p0 <= pick_if;
                  we_p0     <= sel_we;
                  err_p0    <= sel_bad;
                  if_gnt    <= pick_if;
                  dm_gnt    <= !pick_if;
                  mem_en    <= !sel_bad;
                  mem_we    <= sel_we && !sel_bad;
                  mem_addr  <= sel_addr;
                  mem_wdata <= pick_if ? 64'd0 : dm_wdata;
                  if (pick_if || !if_req)
                     sc <= '0;
                  else
                     sc <= sc + 1'b1;
               end else begin
                  state <= IDLE;
                  if (!if_req)
                     sc <= '0;
               end
            end
            ISSUE: begin
               // ISSUE -> RESP: capture memory data for the winning port
               state <= RESP;
               if (win_if_p0) begin
                  if_rvalid <= 1'b1;
                  if_rdata  <= resp_data(mem_rdata, 1'b0, err_p0);
                  if_err    <= err_p0;
               end else begin
                  dm_rvalid <= 1'b1;
                  dm_rdata  <= resp_data(mem_rdata, we_p0, err_p0);
                  dm_err    <= err_p0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [63:0] if_rdata;
   logic        dm_req, dm_we;
   logic [63:0] dm_addr, dm_wdata;
   logic        dm_gnt, dm_rvalid, dm_err;
   logic [63:0] dm_rdata;
   logic        mem_en, mem_we;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [63:0] d;
      logic        e;
   } resp_t;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_err;
      logic        exp_en;
   } vec_t;

   resp_t dmq[$];
   resp_t ifq[$];
   vec_t  vecs[11];

   always #5 clk = ~clk;

   dmem_port_arbiter #(.MEM_BYTES(1024), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Memory model: combinational read so data is present at the edge closing
   // the mem_en cycle; garbage when not enabled.
   logic [7:0] mem [1024];
   logic       mem_clr;

   always_comb begin
      mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      if (mem_en)
         for (int i = 0; i < 8; i++)
            mem_rdata[8*i +: 8] = mem[10'(mem_addr[9:0] + 10'(i))];
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (mem_en && mem_we) begin
         for (int i = 0; i < 8; i++)
            mem[10'(mem_addr[9:0] + 10'(i))] <= mem_wdata[8*i +: 8];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Response scoreboard
   always @(negedge clk) begin
      resp_t r;
      if (!reset) begin
         if (dm_rvalid) begin
            if (dmq.size() == 0) chk("dm_rvalid_unexpected", 64'd1, 64'd0);
            else begin
               r = dmq.pop_front();
               chk("dm_rdata", dm_rdata, r.d);
               chk("dm_err", 64'(dm_err), 64'(r.e));
            end
         end
         if (if_rvalid) begin
            if (ifq.size() == 0) chk("if_rvalid_unexpected", 64'd1, 64'd0);
            else begin
               r = ifq.pop_front();
               chk("if_rdata", if_rdata, r.d);
               chk("if_err", 64'(if_err), 64'(r.e));
            end
         end
         chk("single_grant", 64'(dm_gnt & if_gnt), 64'd0);
      end
   end

   // Called at a negedge; request is sampled at the following posedge.
   task automatic dm_access(input vec_t v);
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
      dmq.push_back('{d: v.exp_rdata, e: v.exp_err});
      @(negedge clk);
      chk("dm_gnt_latency", 64'(dm_gnt), 64'd1);
      for (int n = 0; n < 10 && !dm_gnt; n++) @(negedge clk);
      chk("mem_en", 64'(mem_en), 64'(v.exp_en));
      chk("mem_we", 64'(mem_we), 64'(v.we && v.exp_en));
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      chk("dm_rvalid_latency", 64'(dm_rvalid), 64'd1);
   endtask

   initial begin
      logic pat [10];
      int   k;
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic pat [10];
      int   k;
      pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

      vecs[0]  = '{1'b1, 64'h10,  64'h1,                  64'h0,                  1'b0, 1'b1};
      vecs[1]  = '{1'b0, 64'h10,  64'h0,                  64'h1,                  1'b0, 1'b1};
      vecs[2]  = '{1'b1, 64'h20,  64'h1122334455667788,   64'h0,                  1'b0, 1'b1};
      vecs[3]  = '{1'b0, 64'h20,  64'h0,                  64'h1122334455667788,   1'b0, 1'b1};
      vecs[4]  = '{1'b0, 64'h1C,  64'h0,                  64'h5566778800000000,   1'b0, 1'b1};
      vecs[5]  = '{1'b1, 64'h3F8, 64'hA5A55A5A0F0FF0F0,   64'h0,                  1'b0, 1'b1};
      vecs[6]  = '{1'b0, 64'h3F9, 64'h0,                  64'h0,                  1'b1, 1'b0};
      vecs[7]  = '{1'b1, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFDEADBEEF, 64'h0,      1'b1, 1'b0};
      vecs[8]  = '{1'b0, 64'h3F8, 64'h0,                  64'hA5A55A5A0F0FF0F0,   1'b0, 1'b1};
      vecs[9]  = '{1'b1, 64'h310, 64'h0123456789ABCDEF,   64'h0,                  1'b0, 1'b1};
      vecs[10] = '{1'b0, 64'h312, 64'h0,                  64'h000001234567_89AB,  1'b0, 1'b1};

      reset = 1'b1; mem_clr = 1'b1;
      if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnts",   64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid}), 64'd0);
      chk("rst_mem",    64'({mem_en, mem_we}), 64'd0);
      chk("rst_rdata",  if_rdata | dm_rdata, 64'd0);
      reset = 1'b0; mem_clr = 1'b0;
      @(negedge clk);

      // Table: writes, reads, range errors, boundary
      for (int i = 0; i < 11; i++) dm_access(vecs[i]);

      // Contention: both requests at one edge, data first
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10;
      if_req = 1'b1; if_addr = 64'h312;
      dmq.push_back('{d: 64'h1, e: 1'b0});
      ifq.push_back('{d: 64'h0000012345678_9AB, e: 1'b0});
      @(negedge clk);
      chk("cont_dm_gnt", 64'(dm_gnt), 64'd1);
      chk("cont_if_gnt0", 64'(if_gnt), 64'd0);
      dm_req = 1'b0;
      @(negedge clk);
      chk("cont_if_gnt1", 64'(if_gnt), 64'd0);
      @(negedge clk);
      chk("cont_if_gnt2", 64'(if_gnt), 64'd1);
      if_req = 1'b0;
      @(negedge clk);
      chk("cont_if_rvalid", 64'(if_rvalid), 64'd1);
      @(negedge clk);

      // Starvation guard: both held high continuously
      for (int i = 0; i < 8; i++) dmq.push_back('{d: 64'h1, e: 1'b0});
      for (int i = 0; i < 2; i++) ifq.push_back('{d: 64'h0000012345678_9AB, e: 1'b0});
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10;
      if_req = 1'b1; if_addr = 64'h312;
      k = 0;
      for (int n = 0; n < 40 && k < 10; n++) begin
         @(negedge clk);
         if (dm_gnt || if_gnt) begin
            chk($sformatf("starve_order_%0d", k), 64'(if_gnt), 64'(pat[k]));
            k++;
         end
      end
      chk("starve_grant_count", 64'(k), 64'd10);
      dm_req = 1'b0; if_req = 1'b0;
      repeat (3) @(negedge clk);

      // Reset asserted during ISSUE of a read to 0x10
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10;
      @(negedge clk);
      chk("rst_mid_gnt_before", 64'(dm_gnt), 64'd1);
      reset = 1'b1;
      dm_req = 1'b0;
      #1;
      chk("rst_mid_ctrl", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_err, dm_err}), 64'd0);
      chk("rst_mid_mem", 64'({mem_en, mem_we}), 64'd0);
      chk("rst_mid_addr", mem_addr | mem_wdata, 64'd0);
      chk("rst_mid_rdata", if_rdata | dm_rdata, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("rst_no_rvalid", 64'(dm_rvalid), 64'd0);
      end
      // FSM back in IDLE: a new request is granted with one-cycle latency
      dm_access('{1'b0, 64'h10, 64'h0, 64'h1, 1'b0, 1'b1});
      repeat (3) @(negedge clk);

      chk("dmq_drained", 64'(dmq.size()), 64'd0);
      chk("ifq_drained", 64'(ifq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
